// File: rtl/dma_controller.sv
// Bus-master DMA engine: requests the bus, reads the device one burst at a time
// and writes each burst to memory, then raises a one-cycle completion pulse.
module dma_controller #(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned BURST_WORDS  = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    input  logic [WORD_SIZE-1:0]            cmd_addr,
    input  logic [WORD_SIZE-1:0]            cmd_length,
    output logic                            br,
    input  logic                            bg,
    output logic [WORD_SIZE-1:0]            dev_offset,
    input  logic [WORD_SIZE*BURST_WORDS-1:0] dev_data,
    output logic                            mem_write,
    output logic [WORD_SIZE-1:0]            mem_addr,
    output logic [WORD_SIZE*BURST_WORDS-1:0] mem_data,
    input  logic                            mem_ack,
    output logic                            dma_done
);

    localparam int unsigned NB_W  = WORD_SIZE + 1;
    localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, REQ, FETCH, WRITE, DONE} state_t;

    state_t                           state_q, state_d;
    logic [WORD_SIZE-1:0]             base_q, base_d;
    logic [NB_W-1:0]                  nbursts_q, nbursts_d;
    logic [NB_W-1:0]                  burst_idx_q, burst_idx_d;
    logic [CNT_W-1:0]                 lat_cnt_q, lat_cnt_d;
    logic [WORD_SIZE-1:0]             dev_offset_q, dev_offset_d;
    logic [WORD_SIZE-1:0]             mem_addr_q, mem_addr_d;
    logic [WORD_SIZE*BURST_WORDS-1:0] mem_data_q, mem_data_d;

    logic [NB_W-1:0]      next_idx;
    logic [WORD_SIZE-1:0] burst_off;

    assign next_idx  = burst_idx_q + NB_W'(1);
    assign burst_off = WORD_SIZE'(burst_idx_q * BURST_WORDS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            nbursts_q    <= '0;
            burst_idx_q  <= '0;
            lat_cnt_q    <= '0;
            dev_offset_q <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            nbursts_q    <= nbursts_d;
            burst_idx_q  <= burst_idx_d;
            lat_cnt_q    <= lat_cnt_d;
            dev_offset_q <= dev_offset_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        nbursts_d    = nbursts_q;
        burst_idx_d  = burst_idx_q;
        lat_cnt_d    = lat_cnt_q;
        dev_offset_d = dev_offset_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        br           = 1'b0;
        mem_write    = 1'b0;
        dma_done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    base_d      = cmd_addr;
                    // One extra bit so lengths near 2^WORD_SIZE round up without overflow
                    nbursts_d   = (NB_W'(cmd_length) + NB_W'(BURST_WORDS - 1)) / NB_W'(BURST_WORDS);
                    burst_idx_d = '0;
                    state_d     = (cmd_length == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                br = 1'b1;
                if (bg) begin
                    state_d      = FETCH;
                    lat_cnt_d    = '0;
                    dev_offset_d = burst_off;
                    mem_addr_d   = base_q + burst_off;
                end
            end
            FETCH: begin
                br = 1'b1;
                // Offset is driven from the first FETCH cycle; capture once the
                // device pipeline has had READ_LATENCY full cycles to respond.
                if (lat_cnt_q == CNT_W'(READ_LATENCY)) begin
                    mem_data_d = dev_data;
                    state_d    = WRITE;
                end else begin
                    lat_cnt_d = lat_cnt_q + CNT_W'(1);
                end
            end
            WRITE: begin
                br        = 1'b1;
                mem_write = 1'b1;
                if (mem_ack) begin
                    burst_idx_d = next_idx;
                    state_d     = (next_idx < nbursts_q) ? REQ : DONE;
                end
            end
            DONE: begin
                dma_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dev_offset = dev_offset_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: bus-grant and memory-ack responders,
// a one-cycle-latency device model and expected bursts queued at command time.
module tb_dma_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [15:0] cmd_addr, cmd_length;
    logic        br, bg;
    logic [15:0] dev_offset;
    logic [63:0] dev_data;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [63:0] mem_data;
    logic        mem_ack;
    logic        dma_done;

    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          done_cnt = 0;
    int          bg_cnt = 0, wcnt = 0;
    int          bg_delay = 2, ack_delay = 1;
    bit          bg_hold = 1'b0;
    bit          br_seen = 1'b0, mw_seen = 1'b0;
    logic [15:0] key = 16'h5A00;

    always #5 clk = ~clk;

    dma_controller #(.WORD_SIZE(16), .BURST_WORDS(4), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
        .cmd_length(cmd_length), .br(br), .bg(bg), .dev_offset(dev_offset),
        .dev_data(dev_data), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ack(mem_ack), .dma_done(dma_done)
    );

    function automatic logic [63:0] dev_word(input logic [15:0] off, input logic [15:0] k);
        logic [15:0] w0, w1, w2, w3;
        w0 = off ^ k;
        w1 = (off + 16'd1) ^ k;
        w2 = (off + 16'd2) ^ k;
        w3 = (off + 16'd3) ^ k;
        return {w0, w1, w2, w3};
    endfunction

    // Device with one registered stage between offset and data
    always @(posedge clk) dev_data <= dev_word(dev_offset, key);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            bg      = 1'b0;
            mem_ack = 1'b0;
            bg_cnt  = 0;
            wcnt    = 0;
        end else begin
            if (br) bg_cnt++; else bg_cnt = 0;
            bg = br && (bg_cnt > bg_delay) && !bg_hold;

            if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_write) begin
                wcnt++;
                if (wcnt > ack_delay) begin
                    mem_ack = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", {112'd0, mem_addr}, 128'hFFFF_FFFF);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_addr", {112'd0, mem_addr}, {112'd0, e.addr});
                        check("wr_data", {64'd0, mem_data}, {64'd0, e.data});
                    end
                end
            end

            if (dma_done) begin
                done_cnt++;
                check("done_br_mw_low", {126'd0, br, mem_write}, 128'd0);
            end
            if (br) br_seen = 1'b1;
            if (mem_write) mw_seen = 1'b1;
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] len, input bit expect_it);
        @(negedge clk); #1;
        cmd_addr   = a;
        cmd_length = len;
        cmd_valid  = 1'b1;
        if (expect_it) begin
            for (int b = 0; b < (int'(len) + 3) / 4; b++) begin
                wr_t e;
                e.addr = a + 16'(4 * b);
                e.data = dev_word(16'(4 * b), key);
                exp_q.push_back(e);
            end
        end
        @(negedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit poke);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != start) break;
            @(negedge clk); #1;
        end
        br_seen = 1'b0;
        if (poke) begin
            cmd_addr   = 16'h7700;
            cmd_length = 16'd4;
            cmd_valid  = 1'b1;
            @(negedge clk); #1;
            cmd_valid  = 1'b0;
        end
        repeat (5) @(negedge clk);
        #1;
        check({tag, "_done_once"}, 128'(done_cnt - start), 128'd1);
        check({tag, "_sb_empty"}, 128'(exp_q.size()), 128'd0);
        check({tag, "_br_after"}, {127'd0, br_seen}, 128'd0);
    endtask

    task automatic wait_write(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (mem_write) break;
            @(negedge clk); #1;
        end
        check({tag, "_write_seen"}, {127'd0, mem_write}, 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_length = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {29'd0, br, mem_write, dma_done, dev_offset, mem_addr, mem_data}, 128'd0);
        reset = 1'b0;

        // Three bursts, grant two cycles after request, ack one cycle after write
        key = 16'h1100; bg_delay = 2; ack_delay = 1;
        issue(16'h01F4, 16'd12, 1'b1);
        wait_done("len12", 500, 1'b0);

        // Zero length: done the cycle after the command, no bus activity
        key = 16'h2200; br_seen = 1'b0; mw_seen = 1'b0;
        d0 = done_cnt;
        issue(16'h0100, 16'd0, 1'b1);
        check("len0_done_next", 128'(done_cnt - d0), 128'd1);
        repeat (5) @(negedge clk);
        #1;
        check("len0_no_bus", {126'd0, br_seen, mw_seen}, 128'd0);
        check("len0_done_once", 128'(done_cnt - d0), 128'd1);

        // Partial last burst
        key = 16'h3300; bg_delay = 0;
        issue(16'h0200, 16'd6, 1'b1);
        wait_done("len6", 500, 1'b0);

        // Grant withdrawn during first write, restored five cycles later
        key = 16'h4400; bg_delay = 0; ack_delay = 1;
        issue(16'h0300, 16'd8, 1'b1);
        wait_write("bgdrop", 200);
        bg_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("bgdrop_br_held", {127'd0, br}, 128'd1);
            check("bgdrop_no_fetch", {112'd0, dev_offset}, 128'd0);
        end
        check("bgdrop_first_done", {127'd0, mem_write}, 128'd0);
        check("bgdrop_one_left", 128'(exp_q.size()), 128'd1);
        bg_hold = 1'b0;
        wait_done("bgdrop", 500, 1'b0);

        // Address wrap
        key = 16'h5500; bg_delay = 1;
        issue(16'hFFFC, 16'd8, 1'b1);
        wait_done("wrap", 500, 1'b0);

        // Reset during a write aborts without a completion pulse
        key = 16'h6600; ack_delay = 3;
        issue(16'h0400, 16'd8, 1'b1);
        wait_write("rst", 200);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check("rst_outputs", {29'd0, br, mem_write, dma_done, dev_offset, mem_addr, mem_data}, 128'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("rst_no_done", 128'(done_cnt - d0), 128'd0);
        key = 16'h6700; ack_delay = 1;
        issue(16'h0500, 16'd4, 1'b1);
        wait_done("after_rst", 500, 1'b0);

        // Commands while busy and alongside dma_done are ignored
        key = 16'h7700; bg_delay = 2;
        issue(16'h0600, 16'd8, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        cmd_addr = 16'h7000; cmd_length = 16'd20; cmd_valid = 1'b1;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        wait_done("busy_cmd", 500, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
